// File: rtl/wash_pkg.sv
// Shared types and phase-sequencing constants for the washing-machine program sequencer.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        PH_FILL   = 3'd0,
        PH_WASH   = 3'd1,
        PH_DRAIN  = 3'd2,
        PH_RFILL  = 3'd3,
        PH_RINSE  = 3'd4,
        PH_RDRAIN = 3'd5,
        PH_SPIN   = 3'd6,
        PH_ADRAIN = 3'd7
    } phase_e;

    typedef struct packed {
        logic valve_in;
        logic pump;
        logic motor;
        logic motor_fast;
    } act_t;

    localparam act_t ACT_OFF = '0;

    // Fixed points of the program: entry, rinse-loop entry/re-entry, and the two terminal phases.
    localparam phase_e PH_FIRST       = PH_FILL;
    localparam phase_e PH_AFTER_DRAIN = PH_RFILL;
    localparam phase_e PH_LOOP_BACK   = PH_RFILL;
    localparam phase_e PH_LAST        = PH_SPIN;
    localparam phase_e PH_ABORT       = PH_ADRAIN;

    function automatic logic phase_is_last(input phase_e p);
        return (p == PH_LAST) || (p == PH_ABORT);
    endfunction

endpackage

// File: rtl/wash_phase_sel.sv
// Combinational phase decode: successor phase, timer duration and actuator enables.
module wash_phase_sel
    import wash_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  phase_e             phase,
    input  logic [2:0]         rinse_left,
    input  logic [WIDTH-1:0]   dur_fill,
    input  logic [WIDTH-1:0]   dur_wash,
    input  logic [WIDTH-1:0]   dur_drain,
    input  logic [WIDTH-1:0]   dur_rinse,
    input  logic [WIDTH-1:0]   dur_spin,
    output phase_e             next_phase,
    output logic [WIDTH-1:0]   dur,
    output act_t               act
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        next_phase = phase;
        dur        = '0;
        act        = ACT_OFF;
        case (phase)
            PH_FILL: begin
                next_phase   = PH_WASH;
                dur          = dur_fill;
                act.valve_in = 1'b1;
            end
            PH_WASH: begin
                next_phase = PH_DRAIN;
                dur        = dur_wash;
                act.motor  = 1'b1;
            end
            PH_DRAIN: begin
                next_phase = PH_AFTER_DRAIN;
                dur        = dur_drain;
                act.pump   = 1'b1;
            end
            PH_RFILL: begin
                next_phase   = PH_RINSE;
                dur          = dur_fill;
                act.valve_in = 1'b1;
            end
            PH_RINSE: begin
                next_phase = PH_RDRAIN;
                dur        = dur_rinse;
                act.motor  = 1'b1;
            end
            PH_RDRAIN: begin
                // The counter is decremented on this transition, so loop back only if more than one remains.
                next_phase = (rinse_left > 3'd1) ? PH_LOOP_BACK : PH_LAST;
                dur        = dur_drain;
                act.pump   = 1'b1;
            end
            PH_SPIN: begin
                dur            = dur_spin;
                act.pump       = 1'b1;
                act.motor      = 1'b1;
                act.motor_fast = 1'b1;
            end
            PH_ADRAIN: begin
                dur      = dur_drain;
                act.pump = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: walks fill/wash/drain/rinse/spin, timing each phase
// through the shared interval timer. Outputs are decoded only from the state/phase registers.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int RINSES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] dur_fill,
    input  logic [WIDTH-1:0] dur_wash,
    input  logic [WIDTH-1:0] dur_drain,
    input  logic [WIDTH-1:0] dur_rinse,
    input  logic [WIDTH-1:0] dur_spin,
    output logic [WIDTH-1:0] tmr_set,
    output logic             tmr_load,
    input  logic             tmr_irq,
    output logic             valve_in,
    output logic             pump,
    output logic             motor,
    output logic             motor_fast,
    output logic             door_lock,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [2:0]       phase,
    output logic [2:0]       rinse_left
);

    localparam logic [2:0] RINSE_LOAD = 3'(RINSES);

    state_e     state_q, state_d;
    phase_e     phase_q, phase_d;
    logic [2:0] rinse_left_q, rinse_left_d;
    logic       aborted_q, aborted_d;

    phase_e           next_phase;
    logic [WIDTH-1:0] sel_dur;
    act_t             sel_act;
    logic             abort_take;
    logic             act_on;

    wash_phase_sel #(.WIDTH(WIDTH)) u_sel (
        .phase      (phase_q),
        .rinse_left (rinse_left_q),
        .dur_fill   (dur_fill),
        .dur_wash   (dur_wash),
        .dur_drain  (dur_drain),
        .dur_rinse  (dur_rinse),
        .dur_spin   (dur_spin),
        .next_phase (next_phase),
        .dur        (sel_dur),
        .act        (sel_act)
    );

    assign abort_take = abort && (phase_q != PH_ABORT) &&
                        (state_q inside {ST_ARM, ST_RUN, ST_HOLD});

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        rinse_left_d = rinse_left_q;
        aborted_d    = aborted_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ARM;
                    phase_d      = PH_FIRST;
                    rinse_left_d = RINSE_LOAD;
                    aborted_d    = 1'b0;
                end
            end
            ST_ARM:    state_d = ST_RUN;
            ST_RUN: begin
                if (tmr_irq) begin
                    if (phase_is_last(phase_q)) begin
                        state_d = ST_FINISH;
                    end else begin
                        phase_d = next_phase;
                        if (phase_q == PH_RDRAIN) rinse_left_d = rinse_left_q - 3'd1;
                        state_d = pause ? ST_HOLD : ST_ARM;
                    end
                end
            end
            ST_HOLD:   if (!pause) state_d = ST_ARM;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // Abort overrides whatever the phase logic above decided this cycle.
        if (abort_take) begin
            state_d      = ST_ARM;
            phase_d      = PH_ABORT;
            rinse_left_d = rinse_left_q;
            aborted_d    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_FIRST;
            rinse_left_q <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            rinse_left_q <= rinse_left_d;
            aborted_q    <= aborted_d;
        end
    end

    assign act_on     = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign tmr_load   = (state_q == ST_ARM);
    assign tmr_set    = tmr_load ? sel_dur : '0;
    assign valve_in   = act_on && sel_act.valve_in;
    assign pump       = act_on && sel_act.pump;
    assign motor      = act_on && sel_act.motor;
    assign motor_fast = act_on && sel_act.motor_fast;
    assign door_lock  = act_on || (state_q == ST_HOLD);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);
    assign aborted    = aborted_q;
    assign phase      = phase_q;
    assign rinse_left = rinse_left_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: behavioural interval timer plus a cycle-trace model
// built from the phase rules, with directed pause/abort/reset scenarios.
module tb_wash_sequencer;

    localparam int W  = 16;
    localparam int NR = 1;

    localparam logic [2:0] P_FILL = 3'd0, P_WASH = 3'd1, P_DRAIN = 3'd2, P_RFILL = 3'd3,
                           P_RINSE = 3'd4, P_RDRAIN = 3'd5, P_SPIN = 3'd6, P_ADRAIN = 3'd7;

    logic         clk, rst_n, start, pause, abort;
    logic [W-1:0] dur_fill, dur_wash, dur_drain, dur_rinse, dur_spin;
    logic [W-1:0] tmr_set;
    logic         tmr_load, tmr_irq;
    logic         valve_in, pump, motor, motor_fast, door_lock, busy, done, aborted;
    logic [2:0]   phase, rinse_left;

    int n_tests = 0;
    int n_fail  = 0;

    logic [29:0] exp_q[$];
    bit          exp_arm[$];

    // Behavioural down-counting timer; it is not tied to the sequencer reset.
    logic [W-1:0] t_cnt;
    logic         t_armed;
    logic         irq_force;

    wash_sequencer #(.WIDTH(W), .RINSES(NR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .abort(abort),
        .dur_fill(dur_fill), .dur_wash(dur_wash), .dur_drain(dur_drain),
        .dur_rinse(dur_rinse), .dur_spin(dur_spin),
        .tmr_set(tmr_set), .tmr_load(tmr_load), .tmr_irq(tmr_irq),
        .valve_in(valve_in), .pump(pump), .motor(motor), .motor_fast(motor_fast),
        .door_lock(door_lock), .busy(busy), .done(done), .aborted(aborted),
        .phase(phase), .rinse_left(rinse_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        t_cnt   = '0;
        t_armed = 1'b0;
    end

    always @(posedge clk) begin
        if (tmr_load) begin
            t_cnt   <= tmr_set;
            t_armed <= 1'b1;
        end else if (t_armed) begin
            if (t_cnt == '0) t_armed <= 1'b0;
            else             t_cnt   <= t_cnt - 1'b1;
        end
    end

    assign tmr_irq = (t_armed && (t_cnt == '0)) || irq_force;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [29:0] obs();
        return {phase, rinse_left, tmr_load, tmr_set, valve_in, pump, motor, motor_fast,
                door_lock, busy, done};
    endfunction

    function automatic logic [29:0] pack(input logic [2:0] ph, input logic [2:0] rl,
                                         input logic ld, input logic [15:0] set,
                                         input logic [3:0] act, input logic lock,
                                         input logic bsy, input logic dn);
        return {ph, rl, ld, set, act, lock, bsy, dn};
    endfunction

    // {valve_in, pump, motor, motor_fast} for each phase while it is active.
    function automatic logic [3:0] act_of(input logic [2:0] ph);
        case (ph)
            P_FILL, P_RFILL:            return 4'b1000;
            P_WASH, P_RINSE:            return 4'b0010;
            P_DRAIN, P_RDRAIN, P_ADRAIN: return 4'b0100;
            default:                    return 4'b0111;
        endcase
    endfunction

    function automatic logic [15:0] dur_of(input logic [2:0] ph);
        case (ph)
            P_FILL, P_RFILL:             return dur_fill;
            P_WASH:                      return dur_wash;
            P_DRAIN, P_RDRAIN, P_ADRAIN: return dur_drain;
            P_RINSE:                     return dur_rinse;
            default:                     return dur_spin;
        endcase
    endfunction

    // Expected per-cycle outputs of a full uninterrupted program, starting at the ARM of FILL.
    task automatic build_trace();
        logic [2:0] plist[$];
        logic [2:0] rl;
        int d;
        exp_q.delete();
        exp_arm.delete();
        plist = '{P_FILL, P_WASH, P_DRAIN};
        for (int r = 0; r < NR; r++) begin
            plist.push_back(P_RFILL);
            plist.push_back(P_RINSE);
            plist.push_back(P_RDRAIN);
        end
        plist.push_back(P_SPIN);
        rl = 3'(NR);
        foreach (plist[k]) begin
            d = int'(dur_of(plist[k]));
            exp_q.push_back(pack(plist[k], rl, 1'b1, dur_of(plist[k]), act_of(plist[k]), 1'b1, 1'b1, 1'b0));
            exp_arm.push_back(1'b1);
            for (int c = 0; c <= d; c++) begin
                exp_q.push_back(pack(plist[k], rl, 1'b0, 16'd0, act_of(plist[k]), 1'b1, 1'b1, 1'b0));
                exp_arm.push_back(1'b0);
            end
            if (plist[k] == P_RDRAIN) rl = rl - 3'd1;
        end
        exp_q.push_back(pack(P_SPIN, rl, 1'b0, 16'd0, 4'b0000, 1'b0, 1'b1, 1'b1));
        exp_arm.push_back(1'b0);
        exp_q.push_back(pack(P_SPIN, rl, 1'b0, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b0));
        exp_arm.push_back(1'b0);
    endtask

    // Starts a program from IDLE and compares every cycle against the trace; noise injects
    // ignored starts and stale irqs in ARM. Returns the cycle (start = cycle 0) of done.
    task automatic run_trace(input string name, input bit noise, output int done_cycle);
        logic [29:0] o;
        done_cycle = -1;
        build_trace();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            o = obs();
            n_tests++;
            if (o !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, o, exp_q[i]);
            end
            if (done === 1'b1 && done_cycle < 0) done_cycle = i + 1;
            start     = noise && (i < exp_q.size() - 1) && ($urandom_range(0, 3) == 0);
            irq_force = noise && exp_arm[i] && ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        start     = 1'b0;
        irq_force = 1'b0;
    endtask

    // mode 0: ARM of phase ph; mode 1: RUN cycle of ph with the timer irq present.
    task automatic wait_phase(input logic [2:0] ph, input int mode, input string name);
        bit hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (mode == 0) hit = (phase == ph) && (tmr_load === 1'b1);
            else           hit = (phase == ph) && (tmr_load === 1'b0) && (door_lock === 1'b1) && (tmr_irq === 1'b1);
            if (!hit) @(negedge clk);
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s wait: phase %0d mode %0d never reached (got phase %0d)", name, ph, mode, phase);
        end
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done timeout: got done=%b required 1", name, done);
        end
        @(negedge clk);
    endtask

    task automatic set_plan_durations();
        dur_fill = 16'd3; dur_wash = 16'd5; dur_drain = 16'd2; dur_rinse = 16'd4; dur_spin = 16'd6;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (obs() !== 30'd0 || aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h aborted=%b required 0", obs(), aborted);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_program();
        int dc;
        set_plan_durations();
        run_trace("program", 1'b0, dc);
        n_tests++;
        if (dc != 40) begin
            n_fail++;
            $display("FAIL program_done_cycle: got %0d required 40", dc);
        end
    endtask

    task automatic test_random_programs();
        int dc;
        for (int it = 0; it < 6; it++) begin
            dur_fill  = 16'($urandom_range(0, 6));
            dur_wash  = 16'($urandom_range(0, 6));
            dur_drain = 16'($urandom_range(0, 6));
            dur_rinse = 16'($urandom_range(0, 6));
            dur_spin  = 16'($urandom_range(0, 6));
            run_trace($sformatf("random%0d", it), 1'b1, dc);
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        set_plan_durations();
        dur_wash  = 16'd0;
        irq_force = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_stale_irq: got busy=%b required 0", busy);
            end
        end
        irq_force = 1'b0;
        run_trace("wash_zero", 1'b1, dc);
        run_trace("back_to_back", 1'b1, dc);
    endtask

    task automatic test_pause();
        int cyc;
        logic [29:0] hold_v;
        set_plan_durations();
        hold_v = pack(P_DRAIN, 3'd1, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_phase(P_WASH, 0, "pause");
        pause = 1'b1;
        wait_phase(P_WASH, 1, "pause");
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            n_tests++;
            if (obs() !== hold_v) begin
                n_fail++;
                $display("FAIL pause_hold cycle %0d: got %h expected %h", j, obs(), hold_v);
            end
            irq_force = (j == 4);
        end
        pause = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs() !== pack(P_DRAIN, 3'd1, 1'b1, 16'd2, 4'b0100, 1'b1, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL pause_release_arm: got %h expected %h", obs(),
                     pack(P_DRAIN, 3'd1, 1'b1, 16'd2, 4'b0100, 1'b1, 1'b1, 1'b0));
        end
        wait_done("pause", cyc);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_end_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_abort();
        int k;
        int cyc;
        set_plan_durations();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_phase(P_WASH, 0, "abort");
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (obs() !== pack(P_ADRAIN, 3'd1, 1'b1, 16'd2, 4'b0100, 1'b1, 1'b1, 1'b0) || aborted !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_arm: got %h aborted=%b expected %h aborted=1", obs(), aborted,
                     pack(P_ADRAIN, 3'd1, 1'b1, 16'd2, 4'b0100, 1'b1, 1'b1, 1'b0));
        end
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            abort = (k == 0);
            @(negedge clk);
            k++;
        end
        abort = 1'b0;
        n_tests++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL abort_done_latency: got %0d required 4", k);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || aborted !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_sticky: got busy=%b aborted=%b required 0/1", busy, aborted);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (aborted !== 1'b0 || phase !== P_FILL || tmr_load !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_clear_on_start: got aborted=%b phase=%0d load=%b required 0/0/1",
                     aborted, phase, tmr_load);
        end
        wait_done("abort_rerun", cyc);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_ignored: got busy=%b aborted=%b required 0/0", busy, aborted);
        end
    endtask

    task automatic test_abort_irq();
        int cyc;
        set_plan_durations();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_phase(P_FILL, 1, "abort_irq");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (obs() !== pack(P_ADRAIN, 3'd1, 1'b1, 16'd2, 4'b0100, 1'b1, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL abort_irq_priority: got %h expected %h", obs(),
                     pack(P_ADRAIN, 3'd1, 1'b1, 16'd2, 4'b0100, 1'b1, 1'b1, 1'b0));
        end
        wait_done("abort_irq", cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        set_plan_durations();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_phase(P_SPIN, 0, "reset_mid");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs() !== 30'd0 || aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h aborted=%b required 0", obs(), aborted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (obs() !== pack(P_FILL, 3'd1, 1'b1, 16'd3, 4'b1000, 1'b1, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got %h expected %h", obs(),
                     pack(P_FILL, 3'd1, 1'b1, 16'd3, 4'b1000, 1'b1, 1'b1, 1'b0));
        end
        wait_done("reset_mid", cyc);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;
        irq_force = 1'b0;
        set_plan_durations();
        test_reset();
        test_program();
        test_random_programs();
        test_back_to_back();
        test_pause();
        test_abort();
        test_abort_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
